// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
// Health monitor for a VGA timing source. Samples hsync/vsync/rgb on pixel
// strobes, measures line period, sync widths and lines per frame, checks them
// against the configured mode, tracks lock, flags sticky errors and folds the
// active-area pixels of each frame into a 16-bit signature.
//
// state   | meaning
// SEARCH  | waiting for the first vsync leading edge, nothing is checked
// ACQUIRE | checking; needs one whole clean frame before locking
// LOCKED  | timing matches; frames are counted, any mismatch drops to ACQUIRE
module vga_sync_monitor #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        pix_ce_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [15:0] rgb_i,
  input  logic        clr_i,
  output logic        locked_o,
  output logic        h_err_o,
  output logic        v_err_o,
  output logic [11:0] line_pix_o,
  output logic [11:0] frame_lines_o,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] frame_sig_o
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [11:0] CNT_MAX   = 12'hFFF;
  localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
  localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
  localparam logic [11:0] V_SYNC_C  = 12'(V_SYNC);
  localparam logic [11:0] V_TOTAL_C = 12'(V_TOTAL);
  localparam logic [11:0] H_ACT_LO  = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_ACT_HI  = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] V_ACT_LO  = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_ACT_HI  = 12'(V_SYNC + V_BACK + V_ACTIVE);

  logic [1:0]  state_q, state_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [11:0] h_q, h_d;
  logic [11:0] hw_q, hw_d;
  logic [11:0] v_q, v_d;
  logic [15:0] acc_q, acc_d;
  logic        skip_q, skip_d;
  logic        bad_q, bad_d;
  logic        h_err_q, h_err_d;
  logic        v_err_q, v_err_d;
  logic [11:0] line_pix_q, line_pix_d;
  logic [11:0] frame_lines_q, frame_lines_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] frame_sig_q, frame_sig_d;

  logic        hs_a, vs_a;
  logic        h_lead, h_trail, v_lead, v_trail;
  logic        checking, act, h_mis, v_mis, mis;
  logic [11:0] h_inc, hw_inc, v_inc;

  // Edge detection on the current sample and saturating counter increments.
  always_comb begin
    hs_a    = (hsync_i == SYNC_POL);
    vs_a    = (vsync_i == SYNC_POL);
    h_lead  = pix_ce_i & hs_a & ~hs_prev_q;
    h_trail = pix_ce_i & ~hs_a & hs_prev_q;
    v_lead  = pix_ce_i & vs_a & ~vs_prev_q;
    v_trail = pix_ce_i & ~vs_a & vs_prev_q;
    h_inc   = (h_q == CNT_MAX) ? CNT_MAX : h_q + 12'd1;
    hw_inc  = (hw_q == CNT_MAX) ? CNT_MAX : hw_q + 12'd1;
    v_inc   = (v_q == CNT_MAX) ? CNT_MAX : v_q + 12'd1;
  end

  // Counters, measurements, signature, timing checks, sticky errors and lock FSM.
  always_comb begin
    state_d       = state_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    h_d           = h_q;
    hw_d          = hw_q;
    v_d           = v_q;
    acc_d         = acc_q;
    skip_d        = skip_q;
    bad_d         = bad_q;
    line_pix_d    = line_pix_q;
    frame_lines_d = frame_lines_q;
    frame_cnt_d   = frame_cnt_q;
    frame_sig_d   = frame_sig_q;

    if (pix_ce_i) begin
      hs_prev_d = hs_a;
      vs_prev_d = vs_a;
      h_d       = h_lead ? 12'd0 : h_inc;
      if (h_lead) begin
        hw_d       = 12'd1;
        line_pix_d = h_inc;
      end else if (hs_a) begin
        hw_d = hw_inc;
      end
      if (v_lead) begin
        v_d           = 12'd0;
        frame_lines_d = v_inc;
      end else if (h_lead) begin
        v_d = v_inc;
      end
    end

    // Counter values after this sample's update are the coordinates of the sampled pixel.
    act = pix_ce_i && (h_d >= H_ACT_LO) && (h_d < H_ACT_HI)
                   && (v_d >= V_ACT_LO) && (v_d < V_ACT_HI);
    if (v_lead) begin
      frame_sig_d = acc_q;
      acc_d       = 16'd0;
    end else if (act) begin
      acc_d = {acc_q[14:0], acc_q[15]} ^ rgb_i;
    end

    checking = (state_q != ST_SEARCH);
    h_mis = checking & ((h_lead & ~skip_q & (h_inc != H_TOTAL_C)) |
                        (h_trail & (hw_q != H_SYNC_C)));
    v_mis = checking & ((v_lead & (v_inc != V_TOTAL_C)) |
                        (v_trail & (v_d != V_SYNC_C)));
    mis   = h_mis | v_mis;

    // Set wins over clear.
    h_err_d = h_mis | (h_err_q & ~clr_i);
    v_err_d = v_mis | (v_err_q & ~clr_i);

    case (state_q)
      ST_SEARCH: begin
        if (v_lead) begin
          state_d = ST_ACQUIRE;
          skip_d  = 1'b1;
          bad_d   = 1'b0;
        end
      end
      ST_ACQUIRE: begin
        if (h_lead) skip_d = 1'b0;
        if (v_lead) begin
          state_d = (bad_q | mis) ? ST_ACQUIRE : ST_LOCKED;
          bad_d   = 1'b0;
        end else begin
          bad_d = bad_q | mis;
        end
      end
      ST_LOCKED: begin
        if (v_lead) frame_cnt_d = frame_cnt_q + 16'd1;
        if (mis) begin
          state_d = ST_ACQUIRE;
          skip_d  = 1'b1;
          // A mismatch on the closing vsync edge leaves the next frame clean.
          bad_d   = ~v_lead;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      state_q       <= ST_SEARCH;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      h_q           <= 12'd0;
      hw_q          <= 12'd0;
      v_q           <= 12'd0;
      acc_q         <= 16'd0;
      skip_q        <= 1'b0;
      bad_q         <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      line_pix_q    <= 12'd0;
      frame_lines_q <= 12'd0;
      frame_cnt_q   <= 16'd0;
      frame_sig_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_q           <= h_d;
      hw_q          <= hw_d;
      v_q           <= v_d;
      acc_q         <= acc_d;
      skip_q        <= skip_d;
      bad_q         <= bad_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      line_pix_q    <= line_pix_d;
      frame_lines_q <= frame_lines_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_sig_q   <= frame_sig_d;
    end
  end

  assign locked_o      = (state_q == ST_LOCKED);
  assign h_err_o       = h_err_q;
  assign v_err_o       = v_err_q;
  assign line_pix_o    = line_pix_q;
  assign frame_lines_o = frame_lines_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign frame_sig_o   = frame_sig_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor using a scaled-down video mode so whole frames
// fit in a short run. Each table row describes one generated frame (with an
// optional fault) and the outputs expected at the vsync edge closing it.
module tb_vga_sync_monitor;
  localparam int HS = 4, HB = 3, HA = 8, HT = 20;
  localparam int VS = 2, VB = 2, VA = 5, VT = 12;
  localparam logic SP = 1'b1;

  localparam int NONE = 0, SHORT = 1, HNARROW = 2, VWIDE = 3;
  localparam int ZERO = 0, BARS = 1, RAND = 2;

  typedef struct {
    int nlines;     // lines generated in this frame
    int fault;      // NONE/SHORT/HNARROW/VWIDE
    int fline;      // line carrying the fault
    int rgb_mode;
    int gap_rand;   // 0: pix_ce every 2nd clk, 1: random idle gaps
    int clr_mid;    // clr pulse mid-frame
    int clr_close;  // clr pulse on the vsync edge opening this frame
    int rst_line;   // line with a one-clk reset, -1 for none
    int mid_locked; // locked expected early in the frame
    int f_h, f_v, f_l;             // h_err/v_err/locked at the fault sample
    int chk, chk_lines, chk_sig;   // which closing checks apply
    int e_locked, e_h, e_v, e_cnt; // expected at the closing vsync edge
  } rec_t;

  logic        clk = 1'b0, rst_n = 1'b0, pix_ce = 1'b0, hsync = 1'b0, vsync = 1'b0, clr = 1'b0;
  logic [15:0] rgb = 16'd0;
  logic        locked, h_err, v_err;
  logic [11:0] line_pix, frame_lines;
  logic [15:0] frame_cnt, frame_sig;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT), .SYNC_POL(SP)
  ) dut (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .pix_ce_i(pix_ce),
    .hsync_i(hsync), .vsync_i(vsync), .rgb_i(rgb), .clr_i(clr),
    .locked_o(locked), .h_err_o(h_err), .v_err_o(v_err),
    .line_pix_o(line_pix), .frame_lines_o(frame_lines),
    .frame_cnt_o(frame_cnt), .frame_sig_o(frame_sig)
  );

  int          n_vec = 0, n_err = 0;
  int          gap_rand = 0;
  logic [15:0] bars [8];
  logic [15:0] msig;
  int          prev_len = 0;
  rec_t        pend;
  int          pend_valid = 0;
  rec_t        tbl [15];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, 16'(locked), 16'd0);
    chk({tag, "_h_err"}, 16'(h_err), 16'd0);
    chk({tag, "_v_err"}, 16'(v_err), 16'd0);
    chk({tag, "_line_pix"}, 16'(line_pix), 16'd0);
    chk({tag, "_frame_lines"}, 16'(frame_lines), 16'd0);
    chk({tag, "_frame_cnt"}, frame_cnt, 16'd0);
    chk({tag, "_frame_sig"}, frame_sig, 16'd0);
  endtask

  function automatic int is_act(input int x, input int y);
    return (x >= HS + HB && x < HS + HB + HA && y >= VS + VB && y < VS + VB + VA) ? 1 : 0;
  endfunction

  function automatic logic [15:0] colour(input int x, input int y, input int mode);
    if (is_act(x, y) != 0) begin
      if (mode == ZERO) return 16'd0;
      if (mode == BARS) return bars[((x - HS - HB) * 8) / HA];
      return 16'($urandom);
    end
    return (mode == RAND) ? 16'($urandom) : 16'd0;
  endfunction

  // One pixel sample, preceded by idle cycles carrying garbage that must be ignored.
  task automatic pix(input int hs_on, input int vs_on, input logic [15:0] c,
                     input int do_clr, input int do_rst);
    int g;
    g = (gap_rand != 0) ? int'($urandom_range(3, 0)) : 1;
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      pix_ce = 1'b0;
      hsync  = 1'($urandom);
      vsync  = 1'($urandom);
      rgb    = 16'($urandom);
      clr    = 1'b0;
    end
    @(negedge clk);
    pix_ce = 1'b1;
    hsync  = (hs_on != 0) ? SP : ~SP;
    vsync  = (vs_on != 0) ? SP : ~SP;
    rgb    = c;
    clr    = (do_clr != 0);
    rst_n  = (do_rst == 0);
    @(posedge clk);
    #1;
    clr   = 1'b0;
    rst_n = 1'b1;
  endtask

  // First pixel of a frame: vsync leading edge that closes the previous frame.
  task automatic close_px(input int do_clr, input int mode);
    pix(1, 1, colour(0, 0, mode), do_clr, 0);
    if (pend_valid != 0 && pend.chk != 0) begin
      chk("close_locked", 16'(locked), 16'(pend.e_locked));
      chk("close_h_err", 16'(h_err), 16'(pend.e_h));
      chk("close_v_err", 16'(v_err), 16'(pend.e_v));
      chk("close_frame_cnt", frame_cnt, 16'(pend.e_cnt));
    end
    if (pend_valid != 0 && pend.chk_lines != 0) begin
      chk("close_frame_lines", 16'(frame_lines), 16'(pend.nlines));
      chk("close_line_pix", 16'(line_pix), 16'(prev_len));
    end
    if (pend_valid != 0 && pend.chk_sig != 0)
      chk("close_frame_sig", frame_sig, msig);
    msig = 16'd0;
  endtask

  task automatic gen_frame(input rec_t r);
    int len, hw, vw, fp, do_rst, do_clr;
    logic [15:0] c;
    gap_rand = r.gap_rand;
    close_px(r.clr_close, r.rgb_mode);
    vw = (r.fault == VWIDE) ? VS + 1 : VS;
    for (int y = 0; y < r.nlines; y++) begin
      len = (r.fault == SHORT && y == r.fline) ? HT - 1 : HT;
      hw  = (r.fault == HNARROW && y == r.fline) ? HS - 1 : HS;
      for (int x = 0; x < len; x++) begin
        if (x == 0 && y == 0) continue;
        c      = colour(x, y, r.rgb_mode);
        do_rst = (y == r.rst_line && x == 5) ? 1 : 0;
        do_clr = (r.clr_mid != 0 && y == 2 && x == HS + 2) ? 1 : 0;
        pix((x < hw) ? 1 : 0, (y < vw) ? 1 : 0, c, do_clr, do_rst);
        if (is_act(x, y) != 0) msig = {msig[14:0], msig[15]} ^ c;
        if (do_rst != 0) chk_zero("midrst");
        if (y == 1 && x == HS + 1) chk("mid_locked", 16'(locked), 16'(r.mid_locked));
        fp = ((r.fault == SHORT && y == r.fline + 1 && x == 0) ||
              (r.fault == HNARROW && y == r.fline && x == HS - 1) ||
              (r.fault == VWIDE && y == VS + 1 && x == 0)) ? 1 : 0;
        if (fp != 0) begin
          chk("fault_h_err", 16'(h_err), 16'(r.f_h));
          chk("fault_v_err", 16'(v_err), 16'(r.f_v));
          chk("fault_locked", 16'(locked), 16'(r.f_l));
          chk("fault_line_pix", 16'(line_pix), 16'(prev_len));
        end
      end
      prev_len = len;
    end
    pend       = r;
    pend_valid = 1;
  endtask

  function automatic rec_t mk(int nl, int flt, int fl, int rm, int gr, int cm, int cc, int rl,
                              int ml, int fh, int fv, int flk, int ck, int cl, int cs,
                              int el, int eh, int ev, int ec);
    rec_t r;
    r.nlines = nl; r.fault = flt; r.fline = fl; r.rgb_mode = rm; r.gap_rand = gr;
    r.clr_mid = cm; r.clr_close = cc; r.rst_line = rl; r.mid_locked = ml;
    r.f_h = fh; r.f_v = fv; r.f_l = flk; r.chk = ck; r.chk_lines = cl; r.chk_sig = cs;
    r.e_locked = el; r.e_h = eh; r.e_v = ev; r.e_cnt = ec;
    return r;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    msig = 16'd0;
    //              nl  fault    fl rgb  gr cm cc rl  ml  fh fv fl  ck cl cs  el eh ev cnt
    tbl[0]  = mk(VT,   NONE,    0, BARS, 0, 0, 0, -1, 0,  0, 0, 0,  1, 1, 1,  1, 0, 0, 0);
    tbl[1]  = mk(VT,   NONE,    0, BARS, 0, 0, 0, -1, 1,  0, 0, 0,  1, 1, 1,  1, 0, 0, 1);
    tbl[2]  = mk(VT,   NONE,    0, ZERO, 1, 0, 0, -1, 1,  0, 0, 0,  1, 1, 1,  1, 0, 0, 2);
    tbl[3]  = mk(VT,   SHORT,   5, RAND, 1, 0, 0, -1, 1,  1, 0, 0,  1, 1, 1,  0, 1, 0, 2);
    tbl[4]  = mk(VT,   NONE,    0, BARS, 0, 0, 0, -1, 0,  0, 0, 0,  1, 1, 1,  1, 1, 0, 2);
    tbl[5]  = mk(VT,   NONE,    0, BARS, 0, 1, 0, -1, 1,  0, 0, 0,  1, 1, 1,  1, 0, 0, 3);
    tbl[6]  = mk(VT-1, NONE,    0, BARS, 1, 0, 0, -1, 1,  0, 0, 0,  1, 1, 1,  0, 0, 1, 4);
    tbl[7]  = mk(VT,   NONE,    0, RAND, 1, 0, 1, -1, 0,  0, 0, 0,  1, 1, 1,  1, 0, 1, 4);
    tbl[8]  = mk(VT,   NONE,    0, BARS, 0, 1, 0, -1, 1,  0, 0, 0,  1, 1, 1,  1, 0, 0, 5);
    tbl[9]  = mk(VT,   VWIDE,   0, BARS, 0, 0, 0, -1, 1,  0, 1, 0,  1, 1, 1,  0, 0, 1, 5);
    tbl[10] = mk(VT,   NONE,    0, BARS, 0, 1, 0, -1, 0,  0, 0, 0,  1, 1, 1,  1, 0, 0, 5);
    tbl[11] = mk(VT,   HNARROW, 5, BARS, 1, 0, 0, -1, 1,  1, 0, 0,  1, 1, 1,  0, 1, 0, 5);
    tbl[12] = mk(VT,   NONE,    0, RAND, 1, 0, 0,  3, 0,  0, 0, 0,  1, 0, 0,  0, 0, 0, 0);
    tbl[13] = mk(VT,   NONE,    0, BARS, 0, 0, 0, -1, 0,  0, 0, 0,  1, 1, 1,  1, 0, 0, 0);
    tbl[14] = mk(VT,   NONE,    0, RAND, 1, 0, 0, -1, 1,  0, 0, 0,  1, 1, 1,  1, 0, 0, 1);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) gen_frame(tbl[i]);
    gap_rand = 1;
    close_px(0, RAND);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
